// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and helpers for the serial tx/rx datapath
package serdes_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    localparam int DATA_W_DEF = 8;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit)
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serdes_tx_fifo.sv
// rtl/serdes_tx_fifo.sv - small synchronous FIFO for the tx framer holding buffer
module serdes_tx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    // Pointer update; the extra MSB separates full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) wr_q <= wr_q + 1'b1;
            if (pop && !empty) rd_q <= rd_q + 1'b1;
        end
    end

    // Storage array, no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serdes_tx_framer.sv
// rtl/serdes_tx_framer.sv - A/B pair to framed two-lane serial stream; SERDES_TX_FIFO_EN selects a FIFO holding buffer
module serdes_tx_framer
    import serdes_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GAP_CYCLES = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              start,
    output logic              a_bit,
    output logic              b_bit,
    output logic              busy,
    output logic              frame_done
);
    localparam int CNT_W = cnt_w(DATA_W);
    localparam int GAP_W = 4;

    tx_state_e          state_q;
    logic [DATA_W-1:0]  sh_a_q;
    logic [DATA_W-1:0]  sh_b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               start_q;
    logic               a_bit_q;
    logic               b_bit_q;
    logic               busy_q;
    logic               frame_done_q;

    logic               push;
    logic               pop;
    logic               buf_empty;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;

    assign push = in_valid && in_ready;

`ifdef SERDES_TX_FIFO_EN
    logic buf_full;

    serdes_tx_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  ({head_a, head_b}),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign in_ready = !buf_full;
`else
    logic              hold_v_q;
    logic [DATA_W-1:0] hold_a_q;
    logic [DATA_W-1:0] hold_b_q;

    // Single-entry holding register; push needs it empty, pop needs it full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_q <= 1'b0;
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else if (push) begin
            hold_v_q <= 1'b1;
            hold_a_q <= in_a;
            hold_b_q <= in_b;
        end else if (pop) begin
            hold_v_q <= 1'b0;
        end
    end

    assign buf_empty = !hold_v_q;
    assign head_a    = hold_a_q;
    assign head_b    = hold_b_q;
    // An out-of-range depth setting blocks input rather than passing silently
    assign in_ready  = !hold_v_q && (FIFO_DEPTH >= 2);
`endif

    // Decide whether this enabled edge enters START; the head is popped on that edge
    always_comb begin
        pop = 1'b0;
        if (en && !buf_empty) begin
            case (state_q)
                ST_IDLE:  pop = 1'b1;
                ST_SHIFT: pop = (cnt_q == '0) && (GAP_CYCLES == 0);
                ST_GAP:   pop = (gap_cnt_q == '0);
                default:  pop = 1'b0;
            endcase
        end
    end

    // Frame FSM with shifters and registered outputs; everything holds while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            cnt_q        <= '0;
            gap_cnt_q    <= '0;
            start_q      <= 1'b0;
            a_bit_q      <= 1'b0;
            b_bit_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (en) begin
            if (pop) begin
                state_q      <= ST_START;
                sh_a_q       <= head_a;
                sh_b_q       <= head_b;
                start_q      <= 1'b1;
                busy_q       <= 1'b1;
                a_bit_q      <= 1'b0;
                b_bit_q      <= 1'b0;
                frame_done_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_START: begin
                        state_q      <= ST_SHIFT;
                        start_q      <= 1'b0;
                        a_bit_q      <= sh_a_q[DATA_W-1];
                        b_bit_q      <= sh_b_q[DATA_W-1];
                        sh_a_q       <= sh_a_q << 1;
                        sh_b_q       <= sh_b_q << 1;
                        cnt_q        <= CNT_W'(DATA_W - 1);
                        frame_done_q <= (DATA_W == 1);
                    end
                    ST_SHIFT: begin
                        if (cnt_q != '0) begin
                            a_bit_q      <= sh_a_q[DATA_W-1];
                            b_bit_q      <= sh_b_q[DATA_W-1];
                            sh_a_q       <= sh_a_q << 1;
                            sh_b_q       <= sh_b_q << 1;
                            cnt_q        <= cnt_q - 1'b1;
                            frame_done_q <= (cnt_q == CNT_W'(1));
                        end else begin
                            a_bit_q      <= 1'b0;
                            b_bit_q      <= 1'b0;
                            frame_done_q <= 1'b0;
                            busy_q       <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                            end else begin
                                state_q   <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
                        else                 state_q   <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign start      = start_q;
    assign a_bit      = a_bit_q;
    assign b_bit      = b_bit_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// tb/tb_serdes_tx_framer.sv - scoreboard bench for serdes_tx_framer (instance 0 no gap, instance 1 gap of 3)
module tb_serdes_tx_framer;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       chk_gap;
        logic [3:0] gap;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [1:0] en;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_a [2];
    logic [7:0] in_b [2];
    logic [1:0] start;
    logic [1:0] a_bit;
    logic [1:0] b_bit;
    logic [1:0] busy;
    logic [1:0] frame_done;

    exp_t q0[$];
    exp_t q1[$];

    int n_chk  = 0;
    int n_fail = 0;

    int         coll  [2];
    int         bits  [2];
    int         idle  [2];
    logic [7:0] sa    [2];
    logic [7:0] sb    [2];
    logic [4:0] prev  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        serdes_tx_framer #(
            .DATA_W     (8),
            .GAP_CYCLES ((g == 0) ? 0 : 3),
            .FIFO_DEPTH (4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .en         (en[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_a       (in_a[g]),
            .in_b       (in_b[g]),
            .start      (start[g]),
            .a_bit      (a_bit[g]),
            .b_bit      (b_bit[g]),
            .busy       (busy[g]),
            .frame_done (frame_done[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    // One sampled output cycle of instance id
    task automatic mon(input int id, input logic es, input logic rs);
        exp_t       e;
        logic [4:0] cur;
        cur = {start[id], a_bit[id], b_bit[id], frame_done[id], busy[id]};
        if (rs) begin
            coll[id] = 0;
            chk("reset_outs", int'(cur), 0);
        end else if (!es) begin
            chk("stall_hold", int'(cur), int'(prev[id]));
        end else if (start[id]) begin
            chk("start_in_frame", coll[id], 0);
            chk("start_lanes", int'({a_bit[id], b_bit[id], frame_done[id]}), 0);
            chk("start_busy", int'(busy[id]), 1);
            if (qsize(id) == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = (id == 0) ? q0[0] : q1[0];
                if (e.chk_gap) chk("gap_len", idle[id], int'(e.gap));
            end
            coll[id] = 1;
            bits[id] = 0;
            sa[id]   = '0;
            sb[id]   = '0;
        end else if (coll[id] != 0) begin
            sa[id] = {sa[id][6:0], a_bit[id]};
            sb[id] = {sb[id][6:0], b_bit[id]};
            bits[id]++;
            chk("frame_done", int'(frame_done[id]), (bits[id] == 8) ? 1 : 0);
            chk("shift_busy", int'(busy[id]), 1);
            if (bits[id] == 8) begin
                coll[id] = 0;
                idle[id] = 0;
                if (qsize(id) != 0) begin
                    if (id == 0) e = q0.pop_front();
                    else         e = q1.pop_front();
                    chk("lane_a", int'(sa[id]), int'(e.a));
                    chk("lane_b", int'(sb[id]), int'(e.b));
                end
            end
        end else begin
            chk("idle_outs", int'(cur), 0);
            idle[id]++;
        end
        prev[id] = cur;
    endtask

    // Monitor: note en/rst at the edge, then judge the outputs just after it
    initial begin
        logic [1:0] es;
        logic [1:0] rs;
        for (int i = 0; i < 2; i++) begin
            coll[i] = 0; bits[i] = 0; idle[i] = 0; sa[i] = '0; sb[i] = '0; prev[i] = '0;
        end
        forever begin
            @(posedge clk);
            es = en;
            rs = rst;
            #1;
            mon(0, es[0], rs[0]);
            mon(1, es[1], rs[1]);
        end
    end

    task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic chk_gap, input logic [3:0] gap);
        int t;
        exp_t e;
        e = '{a: a, b: b, chk_gap: chk_gap, gap: gap};
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
        @(negedge clk);
        in_valid[id] = 1'b1;
        in_a[id]     = a;
        in_b[id]     = b;
        t = 0;
        while (!in_ready[id] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[id]) begin
            chk("accept_timeout", 0, 1);
            in_valid[id] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid[id] = 1'b0;
        end
    endtask

    task automatic drain(input int id);
        int t;
        t = 0;
        while (qsize(id) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", qsize(id), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input int id);
        int t;
        t = 0;
        while (!start[id] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("wait_start", int'(start[id]), 1);
    endtask

    initial begin
        int cap;
        rst      = 2'b11;
        en       = 2'b11;
        in_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            in_a[i] = '0;
            in_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 2'b00;
        @(negedge clk);
        chk("ready_after_rst0", int'(in_ready[0]), 1);
        chk("ready_after_rst1", int'(in_ready[1]), 1);

        // Basic frame with latency check
        send(0, 8'h02, 8'h03, 1'b0, 4'd0);
        @(posedge clk);
        #1;
        chk("lat_start", int'(start[0]), 1);
        @(posedge clk);
        #1;
        chk("lat_msb_a", int'(a_bit[0]), 0);
        drain(0);

        // Back-to-back frames, no idle cycle between
        send(0, 8'hA5, 8'h5A, 1'b0, 4'd0);
        send(0, 8'hFF, 8'h00, 1'b1, 4'd0);
        drain(0);

        // Gap of three idle cycles
        send(1, 8'hC3, 8'h3C, 1'b0, 4'd0);
        send(1, 8'h81, 8'h7E, 1'b1, 4'd3);
        drain(1);

        // Stall during bit 5
        send(0, 8'h80, 8'h01, 1'b0, 4'd0);
        wait_start(0);
        repeat (5) @(negedge clk);
        en[0] = 1'b0;
        repeat (4) @(negedge clk);
        en[0] = 1'b1;
        drain(0);

        // Backpressure with the FSM held off
`ifdef SERDES_TX_FIFO_EN
        cap = 4;
`else
        cap = 1;
`endif
        @(negedge clk);
        en[0] = 1'b0;
        for (int i = 0; i < cap; i++) send(0, 8'h11 + 8'(i), 8'h22 + 8'(i), 1'b0, 4'd0);
        @(negedge clk);
        chk("bp_full", int'(in_ready[0]), 0);
        en[0] = 1'b1;
        @(negedge clk);
        chk("bp_start", int'(start[0]), 1);
        chk("bp_ready_rise", int'(in_ready[0]), 1);
        drain(0);

        // Reset mid-frame drops the frame
        send(0, 8'hFF, 8'hFF, 1'b0, 4'd0);
        wait_start(0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(busy[0]), 1);
        chk("pre_rst_a", int'(a_bit[0]), 1);
        rst[0] = 1'b1;
        #1;
        chk("rst_outs", int'({start[0], a_bit[0], b_bit[0], busy[0], frame_done[0]}), 0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("ready_after_mid_rst", int'(in_ready[0]), 1);
        send(0, 8'h5C, 8'hA3, 1'b0, 4'd0);
        drain(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
